// File: rtl/store_write_buffer_pkg.sv
// store_write_buffer_pkg: shared widths, size encodings and entry layout for the store write buffer.
package store_write_buffer_pkg;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_3B = 2'b10;
    localparam logic [1:0] SZ_4B = 2'b11;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    size;
        logic          cachable;
    } entry_t;
endpackage

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: write-back, D-cache, load-lookup and status signals of the store write buffer.
interface store_write_buffer_if;
    import store_write_buffer_pkg::*;
    logic          wr_v;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_size;
    logic          wr_cachable;
    logic          wb_stall;
    logic          full;
    logic          empty;
    logic [PTRW:0] count;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_data;
    logic [1:0]    dc_size;
    logic          dc_cachable;
    logic          dc_ack;
    logic          ld_v;
    logic [AW-1:0] ld_addr;
    logic [1:0]    ld_size;
    logic          ld_conflict;
    logic          drain;
    logic          drained;
    modport master (
        output wr_v, wr_addr, wr_data, wr_size, wr_cachable, dc_ack, ld_v, ld_addr, ld_size, drain,
        input  wb_stall, full, empty, count, dc_req, dc_addr, dc_data, dc_size, dc_cachable,
               ld_conflict, drained
    );
    modport slave (
        input  wr_v, wr_addr, wr_data, wr_size, wr_cachable, dc_ack, ld_v, ld_addr, ld_size, drain,
        output wb_stall, full, empty, count, dc_req, dc_addr, dc_data, dc_size, dc_cachable,
               ld_conflict, drained
    );
endinterface

// File: rtl/store_write_buffer_overlap_cmp.sv
// sb_overlap_cmp: byte-range overlap of one buffered store against a load lookup.
module sb_overlap_cmp
    import store_write_buffer_pkg::*;
(
    input  logic          valid_i,
    input  logic [AW-1:0] a_i,
    input  logic [1:0]    size_i,
    input  logic [AW-1:0] l_i,
    input  logic [1:0]    ld_size_i,
    output logic          hit_o
);
    // Range ends carry one extra bit so a range near the top of memory never wraps to 0.
    logic [AW:0] a_end, l_end;
    assign a_end = {1'b0, a_i} + {{(AW-1){1'b0}}, size_i};
    assign l_end = {1'b0, l_i} + {{(AW-1){1'b0}}, ld_size_i};
    assign hit_o = valid_i & ({1'b0, l_i} <= a_end) & ({1'b0, a_i} <= l_end);
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order posted store FIFO draining to the D-cache, with load-overlap detection.
module store_write_buffer
    import store_write_buffer_pkg::*;
(
    input logic                clk,
    input logic                rst,
    store_write_buffer_if.slave sb
);
    entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, hit;
    logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTRW:0]   count_q, count_d;
    logic            full, empty, enq, deq;
    assign full  = count_q == (PTRW+1)'(DEPTH);
    assign empty = count_q == '0;
    // Fullness comes from registered count, so a slot freed by dc_ack is reused only next cycle.
    assign enq   = sb.wr_v & ~full;
    assign deq   = sb.dc_ack & ~empty;
    always_comb begin
        valid_d = valid_q;
        if (deq) valid_d[head_q] = 1'b0;
        if (enq) valid_d[tail_q] = 1'b1;
        head_d  = deq ? head_q + 1'b1 : head_q;
        tail_d  = enq ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (PTRW+1)'(enq) - (PTRW+1)'(deq);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (enq) ent_q[tail_q] <= '{addr: sb.wr_addr, data: sb.wr_data, size: sb.wr_size, cachable: sb.wr_cachable};
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        sb_overlap_cmp u_cmp (
            .valid_i   (valid_q[i]),
            .a_i       (ent_q[i].addr),
            .size_i    (ent_q[i].size),
            .l_i       (sb.ld_addr),
            .ld_size_i (sb.ld_size),
            .hit_o     (hit[i])
        );
    end
    assign sb.full        = full;
    assign sb.empty       = empty;
    assign sb.count       = count_q;
    assign sb.wb_stall    = sb.wr_v & full;
    assign sb.dc_req      = ~empty;
    assign sb.dc_addr     = ent_q[head_q].addr;
    assign sb.dc_data     = ent_q[head_q].data;
    assign sb.dc_size     = ent_q[head_q].size;
    assign sb.dc_cachable = ent_q[head_q].cachable;
    assign sb.ld_conflict = sb.ld_v & |hit;
    assign sb.drained     = empty & ~sb.dc_req;
endmodule
